// File: rtl/verisparse_pkg.sv
// Shared types and constants for the sparse-recovery datapath.
//
// Contents:
//   fp_32_t        signed 32-bit sample word
//   FP32_MAX/MIN   extreme representable sample values
//   argmax_state_t state encoding of the streaming arg-max reduction
//   sat_abs()      saturating absolute value (-2^31 maps to FP32_MAX)
package verisparse_pkg;

    typedef logic signed [31:0] fp_32_t;

    localparam fp_32_t FP32_MAX = 32'sh7FFF_FFFF;
    localparam fp_32_t FP32_MIN = 32'sh8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } argmax_state_t;

    // Two's complement negation of FP32_MIN wraps to itself, so it is
    // clamped to the largest positive value instead.
    function automatic fp_32_t sat_abs(input fp_32_t x);
        fp_32_t r;
        if (x == FP32_MIN) begin
            r = FP32_MAX;
        end else if (x[31]) begin
            r = -x;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/abs_argmax_stream_fp32_if.sv
// Stream interface of the arg-max reduction: sample input channel and
// result output channel, both valid/ready.
//
// Signals:
//   in_valid/in_ready/in_data/in_last     sample stream (source -> block)
//   out_valid/out_ready                   result handshake (block -> sink)
//   out_value/out_index/out_count         winning value, its index, frame length
//   out_overflow                          frame was cut at the maximum length
// Modports:
//   slave   the reduction block
//   master  the surrounding datapath (sample source and result sink)
interface abs_argmax_stream_fp32_if
    import verisparse_pkg::*;
#(
    parameter int IDX_W = 10
);

    logic             in_valid;
    logic             in_ready;
    fp_32_t           in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    fp_32_t           out_value;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W:0]   out_count;
    logic             out_overflow;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_value, out_index, out_count, out_overflow
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_index, out_count, out_overflow
    );

endinterface

// File: rtl/fp32_sat_abs.sv
// Combinational saturating absolute value of an fp_32_t sample.
// Shared by the magnitude-based reduction blocks.
//
// Ports:
//   i_data  input  fp_32_t  signed sample
//   o_abs   output fp_32_t  |i_data|, with -2^31 clamped to FP32_MAX
module fp32_sat_abs
    import verisparse_pkg::*;
(
    input  fp_32_t i_data,
    output fp_32_t o_abs
);

    assign o_abs = sat_abs(i_data);

endmodule

// File: rtl/abs_argmax_stream_fp32.sv
// Streaming arg-max reduction. Consumes one frame of fp_32_t samples
// (terminated by in_last, or force-terminated at MAX_LEN samples) and
// presents the largest magnitude, its 0-based index and the frame length.
//
// Ports:
//   clock      input   clock, all logic on posedge
//   resetN     input   synchronous active-low reset
//   io_stream  slave modport of abs_argmax_stream_fp32_if
//
// Parameters:
//   MAX_LEN  maximum samples per frame
//   IDX_W    index width, $clog2(MAX_LEN)
//   USE_ABS  1: compare saturating |x|; 0: compare signed x
//
// State | meaning
// IDLE  | no sample of the current frame accepted yet
// ACCUM | frame in progress, running best/index/count valid
// DONE  | result held on out_*, waiting for the consumer
module abs_argmax_stream_fp32
    import verisparse_pkg::*;
#(
    parameter int MAX_LEN = 1024,
    parameter int IDX_W   = $clog2(MAX_LEN),
    parameter bit USE_ABS = 1'b1
)(
    input  logic                    clock,
    input  logic                    resetN,
    abs_argmax_stream_fp32_if.slave io_stream
);

    localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(MAX_LEN);

    argmax_state_t    r_state;
    fp_32_t           r_best;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W:0]   r_count;
    logic             r_overflow;
    logic             r_in_ready;
    logic             r_out_valid;

    fp_32_t           w_mag;
    logic             w_accept;
    logic             w_take;
    logic             w_better;
    logic             w_hit_max;
    logic             w_end;
    logic [IDX_W:0]   w_new_count;

    generate
        if (USE_ABS) begin : g_abs
            fp32_sat_abs u_sat_abs (
                .i_data (io_stream.in_data),
                .o_abs  (w_mag)
            );
        end else begin : g_raw
            assign w_mag = io_stream.in_data;
        end
    endgenerate

    always_comb begin
        w_accept    = io_stream.in_valid && r_in_ready;
        w_take      = r_out_valid && io_stream.out_ready;
        // Length of the frame including the beat currently offered.
        w_new_count = (r_state == IDLE) ? CNT_ONE : (r_count + CNT_ONE);
        // Strict compare keeps the earliest index on ties.
        w_better    = (w_mag > r_best);
        w_hit_max   = (w_new_count == CNT_MAX);
        w_end       = io_stream.in_last || w_hit_max;
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_best      <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (w_accept) begin
                        r_best  <= w_mag;
                        r_idx   <= '0;
                        r_count <= w_new_count;
                        if (w_end) begin
                            r_state     <= DONE;
                            r_overflow  <= !io_stream.in_last;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end

                ACCUM: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (w_accept) begin
                        if (w_better) begin
                            r_best <= w_mag;
                            // r_count is the 0-based index of this beat and is
                            // below MAX_LEN here, so the truncation is exact.
                            r_idx  <= r_count[IDX_W-1:0];
                        end
                        r_count <= w_new_count;
                        if (w_end) begin
                            r_state     <= DONE;
                            r_overflow  <= !io_stream.in_last;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (w_take) begin
                        r_state     <= IDLE;
                        r_overflow  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Result fields come straight from the frozen running registers.
    assign io_stream.in_ready     = r_in_ready;
    assign io_stream.out_valid    = r_out_valid;
    assign io_stream.out_value    = r_best;
    assign io_stream.out_index    = r_idx;
    assign io_stream.out_count    = r_count;
    assign io_stream.out_overflow = r_overflow;

endmodule

// File: tb/tb_abs_argmax_stream_fp32.sv
// Self-checking bench for abs_argmax_stream_fp32.
// Unit 0: USE_ABS=1, MAX_LEN=4.  Unit 1: USE_ABS=0, MAX_LEN=16.
// Results are checked against a frame-level reference model.
module tb_abs_argmax_stream_fp32;
    import verisparse_pkg::*;

    localparam int MAXL0 = 4;
    localparam int MAXL1 = 16;
    localparam int IW0   = $clog2(MAXL0);
    localparam int IW1   = $clog2(MAXL1);

    typedef logic [31:0] word_q_t[$];

    typedef struct packed {
        logic [31:0] value;
        logic [15:0] index;
        logic [15:0] count;
        logic        ovf;
    } res_t;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    abs_argmax_stream_fp32_if #(.IDX_W(IW0)) bus0 ();
    abs_argmax_stream_fp32_if #(.IDX_W(IW1)) bus1 ();

    abs_argmax_stream_fp32 #(.MAX_LEN(MAXL0), .IDX_W(IW0), .USE_ABS(1'b1)) dut0 (
        .clock     (clock),
        .resetN    (resetN),
        .io_stream (bus0.slave)
    );

    abs_argmax_stream_fp32 #(.MAX_LEN(MAXL1), .IDX_W(IW1), .USE_ABS(1'b0)) dut1 (
        .clock     (clock),
        .resetN    (resetN),
        .io_stream (bus1.slave)
    );

    logic [1:0]       drv_valid;
    logic [1:0]       drv_last;
    logic [1:0][31:0] drv_data;
    logic [1:0]       drv_ready;
    logic [1:0]       stall;

    logic [1:0]       ob_in_ready;
    logic [1:0]       ob_out_valid;
    logic [1:0]       ob_ovf;
    logic [1:0][31:0] ob_value;
    logic [1:0][15:0] ob_index;
    logic [1:0][15:0] ob_count;

    assign bus0.in_valid  = drv_valid[0];
    assign bus0.in_last   = drv_last[0];
    assign bus0.in_data   = drv_data[0];
    assign bus0.out_ready = drv_ready[0];
    assign bus1.in_valid  = drv_valid[1];
    assign bus1.in_last   = drv_last[1];
    assign bus1.in_data   = drv_data[1];
    assign bus1.out_ready = drv_ready[1];

    assign ob_in_ready  = {bus1.in_ready, bus0.in_ready};
    assign ob_out_valid = {bus1.out_valid, bus0.out_valid};
    assign ob_ovf       = {bus1.out_overflow, bus0.out_overflow};
    assign ob_value[0]  = bus0.out_value;
    assign ob_value[1]  = bus1.out_value;
    assign ob_index[0]  = 16'(bus0.out_index);
    assign ob_index[1]  = 16'(bus1.out_index);
    assign ob_count[0]  = 16'(bus0.out_count);
    assign ob_count[1]  = 16'(bus1.out_count);

    int   n_checks = 0;
    int   n_errors = 0;
    res_t q0[$];
    res_t q1[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint mag_of(input int u, input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        if (u == 0) begin
            if (v < 0) v = -v;
            if (v > 64'sd2147483647) v = 64'sd2147483647;
        end
        return v;
    endfunction

    function automatic void push_exp(input int u, input res_t r);
        if (u == 0) q0.push_back(r);
        else        q1.push_back(r);
    endfunction

    function automatic int q_size(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    // Splits a frame into MAX_LEN-sized pieces; every piece except the one
    // carrying the last sample was cut short and reports overflow.
    function automatic void model_frame(input int u, input word_q_t s);
        int     maxl;
        int     start;
        int     n;
        int     bi;
        longint bm;
        res_t   r;
        maxl  = (u == 0) ? MAXL0 : MAXL1;
        start = 0;
        while (start < s.size()) begin
            n     = s.size() - start;
            r.ovf = 1'b0;
            if (n > maxl) begin
                n     = maxl;
                r.ovf = 1'b1;
            end
            bi = 0;
            bm = mag_of(u, s[start]);
            for (int i = 1; i < n; i++) begin
                if (mag_of(u, s[start + i]) > bm) begin
                    bm = mag_of(u, s[start + i]);
                    bi = i;
                end
            end
            r.value = 32'(bm);
            r.index = 16'(bi);
            r.count = 16'(n);
            push_exp(u, r);
            start += n;
        end
    endfunction

    // ---------------- drivers / monitor ----------------
    task automatic send_beat(input int u, input logic [31:0] d, input logic last);
        int w;
        drv_valid[u] = 1'b1;
        drv_data[u]  = d;
        drv_last[u]  = last;
        w = 0;
        while (!ob_in_ready[u] && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (w >= 100) chk($sformatf("u%0d in_ready_timeout", u), 64'(ob_in_ready[u]), 64'd1);
        @(posedge clock);
        @(negedge clock);
        drv_valid[u] = 1'b0;
        drv_last[u]  = 1'b0;
    endtask

    task automatic send_frame(input int u, input word_q_t s, input bit gaps);
        int   maxl;
        int   pos;
        logic last;
        maxl = (u == 0) ? MAXL0 : MAXL1;
        pos  = 0;
        model_frame(u, s);
        for (int i = 0; i < s.size(); i++) begin
            last = (i == s.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clock);
            send_beat(u, s[i], last);
            pos++;
            if (last || pos == maxl) begin
                pos = 0;
                chk($sformatf("u%0d latency_out_valid", u), 64'(ob_out_valid[u]), 64'd1);
                chk($sformatf("u%0d done_in_ready", u), 64'(ob_in_ready[u]), 64'd0);
            end
        end
    endtask

    task automatic monitor(input int u);
        res_t e;
        forever begin
            @(negedge clock);
            drv_ready[u] = stall[u] ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (ob_out_valid[u] && drv_ready[u]) begin
                if (q_size(u) == 0) begin
                    chk($sformatf("u%0d unexpected_result", u), 64'(ob_out_valid[u]), 64'd0);
                end else begin
                    e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("u%0d value", u), 64'(ob_value[u]), 64'(e.value));
                    chk($sformatf("u%0d index", u), 64'(ob_index[u]), 64'(e.index));
                    chk($sformatf("u%0d count", u), 64'(ob_count[u]), 64'(e.count));
                    chk($sformatf("u%0d overflow", u), 64'(ob_ovf[u]), 64'(e.ovf));
                end
            end
        end
    endtask

    task automatic drain(input int u);
        int w;
        w = 0;
        while (q_size(u) != 0 && w < 300) begin
            @(negedge clock);
            w++;
        end
        if (w >= 300) chk($sformatf("u%0d drain_pending", u), 64'(q_size(u)), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_zero_outputs(input int u, input string when);
        chk($sformatf("u%0d %s in_ready", u, when), 64'(ob_in_ready[u]), 64'd0);
        chk($sformatf("u%0d %s out_valid", u, when), 64'(ob_out_valid[u]), 64'd0);
        chk($sformatf("u%0d %s out_value", u, when), 64'(ob_value[u]), 64'd0);
        chk($sformatf("u%0d %s out_index", u, when), 64'(ob_index[u]), 64'd0);
        chk($sformatf("u%0d %s out_count", u, when), 64'(ob_count[u]), 64'd0);
        chk($sformatf("u%0d %s out_overflow", u, when), 64'(ob_ovf[u]), 64'd0);
    endtask

    function automatic logic [31:0] rand_sample();
        logic [31:0] r;
        case ($urandom_range(0, 6))
            0:       r = 32'h8000_0000;
            1:       r = 32'h7FFF_FFFF;
            2, 3:    r = 32'($signed($urandom_range(0, 20)) - 10);
            default: r = $urandom();
        endcase
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_q_t f;
        word_q_t g;
        int      u;
        int      len;

        drv_valid = '0;
        drv_last  = '0;
        drv_data  = '0;
        drv_ready = '0;
        stall     = '0;
        resetN    = 1'b0;
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(negedge clock);
        chk_zero_outputs(0, "reset");
        chk_zero_outputs(1, "reset");
        resetN = 1'b1;
        @(negedge clock);
        chk("u0 post_reset in_ready", 64'(ob_in_ready[0]), 64'd1);
        chk("u1 post_reset in_ready", 64'(ob_in_ready[1]), 64'd1);

        // Abs mode with a tie (-7 vs 7), held under backpressure while the
        // next frame is already being offered.
        stall[0] = 1'b1;
        f.delete();
        f.push_back(32'd3); f.push_back(32'hFFFF_FFF9); f.push_back(32'd5); f.push_back(32'd7);
        send_frame(0, f, 1'b0);
        g.delete();
        g.push_back(32'd2); g.push_back(32'hFFFF_FFF6); g.push_back(32'd4);
        fork
            send_frame(0, g, 1'b0);
            begin
                for (int k = 0; k < 5; k++) begin
                    chk("u0 stall out_valid", 64'(ob_out_valid[0]), 64'd1);
                    chk("u0 stall in_ready", 64'(ob_in_ready[0]), 64'd0);
                    chk("u0 stall out_value", 64'(ob_value[0]), 64'd7);
                    chk("u0 stall out_index", 64'(ob_index[0]), 64'd1);
                    chk("u0 stall out_count", 64'(ob_count[0]), 64'd4);
                    chk("u0 stall out_overflow", 64'(ob_ovf[0]), 64'd0);
                    @(negedge clock);
                end
                stall[0] = 1'b0;
            end
        join
        drain(0);

        // Signed mode and single-sample frame.
        f.delete();
        f.push_back(32'hFFFF_FFFB); f.push_back(32'hFFFF_FFFE); f.push_back(32'hFFFF_FFF7);
        send_frame(1, f, 1'b0);
        f.delete();
        f.push_back(32'hFFFF_FFFC);
        send_frame(1, f, 1'b0);
        drain(1);

        // Saturating magnitude of the most negative value.
        f.delete();
        f.push_back(32'h8000_0000); f.push_back(32'd100);
        send_frame(0, f, 1'b0);
        drain(0);

        // Forced termination at MAX_LEN, then the remainder as its own frame.
        f.delete();
        f.push_back(32'd1); f.push_back(32'd9); f.push_back(32'd2);
        f.push_back(32'd3); f.push_back(32'd8); f.push_back(32'd4);
        send_frame(0, f, 1'b0);
        drain(0);

        // Reset in the middle of a frame discards it.
        send_beat(0, 32'd50, 1'b0);
        send_beat(0, 32'd60, 1'b0);
        resetN = 1'b0;
        @(negedge clock);
        chk_zero_outputs(0, "midframe_reset");
        resetN = 1'b1;
        @(negedge clock);
        chk("u0 reset_release in_ready", 64'(ob_in_ready[0]), 64'd1);
        f.delete();
        f.push_back(32'd6); f.push_back(32'd2);
        send_frame(0, f, 1'b0);
        drain(0);

        // Random frames on both units.
        for (int n = 0; n < 60; n++) begin
            u   = $urandom_range(0, 1);
            len = $urandom_range(1, (u == 0) ? 9 : 20);
            f.delete();
            for (int i = 0; i < len; i++) f.push_back(rand_sample());
            send_frame(u, f, 1'b1);
        end
        drain(0);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/abs_argmax_stream_fp32.md
Name: abs_argmax_stream_fp32

Overview:
Streaming reduction that consumes a frame of fp_32_t samples over a valid/ready input and returns the largest magnitude, its position in the frame and the frame length over a valid/ready result port. Sits downstream of the correlator in the sparse-recovery datapath, where atom selection needs the index as well as the value. The running max registers hold only per-frame state. A frame is delimited by in_last.

Parameters:
MAX_LEN, 1024, maximum samples per frame; a frame reaching this length is force-terminated.
IDX_W, $clog2(MAX_LEN), width of sample index.
USE_ABS, 1, 1 = compare |x| (saturating); 0 = compare signed x.

Ports:
clock  input  1  clock; all logic on posedge.
resetN  input  1  reset, synchronous, active-low.
in_valid  input  1  sample valid.
in_ready  output  1  block can accept a sample.
in_data  input  32  sample, fp_32_t (signed).
in_last  input  1  final sample of frame.
out_valid  output  1  result valid.
out_ready  input  1  result consumer ready.
out_value  output  32  winning magnitude (USE_ABS=1) or winning signed value (USE_ABS=0), fp_32_t.
out_index  output  IDX_W  0-based index of the winner within the frame.
out_count  output  IDX_W+1  number of samples in the frame.
out_overflow  output  1  frame was cut at MAX_LEN without in_last.

Behaviour:
- Beat accepted when in_valid && in_ready. Result taken when out_valid && out_ready.
- Magnitude mag(x) depends on USE_ABS:
  - USE_ABS=1: mag(x) = x<0 ? -x : x, with -2^31 saturating to 32'h7FFFFFFF.
  - USE_ABS=0: mag(x) = x.
  - Comparison is signed in both modes.
- States: IDLE (no sample of current frame yet), ACCUM, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an accepted beat: best<=mag, idx<=0, count<=1.
  - Next state is DONE if in_last; otherwise ACCUM.
- ACCUM:
  - in_ready=1, out_valid=0.
  - On an accepted beat: if mag > best (strict), best<=mag and idx<=count. count<=count+1.
  - Ties keep the earliest index.
- Frame end:
  - A beat with in_last set goes to DONE. The result includes that beat.
  - A beat reaching count==MAX_LEN without in_last also goes to DONE, with overflow<=1. The next beat starts a new frame in IDLE.
- DONE:
  - in_ready=0, out_valid=1.
  - out_* are registered and held stable until taken.
  - When taken, state<=IDLE and overflow<=0.
- Latency: out_valid rises exactly 1 cycle after the terminating beat is accepted.
- Throughput: one bubble cycle per frame, because in_ready=0 for at least the single DONE cycle.
- in_valid without in_ready: no state change; the source must hold its data.
- out_ready high while out_valid=0: ignored.
- Reset (resetN=0 at posedge), from any state including mid-frame or DONE:
  - state=IDLE, out_valid=0, out_value=0, out_index=0, out_count=0, out_overflow=0, internal best/idx/count=0.
  - The partial frame is discarded.
  - in_ready is 0 during the reset cycle and 1 from the following cycle.
- out_value/out_index/out_count are driven from the best/idx/count registers, which are frozen in DONE. No combinational path exists from in_* to out_*.

Decomposition:
- Shared package verisparse_pkg holds:
  - fp_32_t (signed 32-bit)
  - constants FP32_MAX = 32'h7FFFFFFF and FP32_MIN = 32'h80000000
  - enum argmax_state_t {IDLE, ACCUM, DONE}
- One sub-module: fp32_sat_abs, a combinational saturating absolute value. It is reusable by the other magnitude blocks and bypassed when USE_ABS=0.

Test Plan:
1. USE_ABS=1, frame {3, -7, 5, 7(last)} -> out_value=7, out_index=1 (earliest tie), out_count=4, overflow=0; out_valid on the cycle after the last beat.
2. USE_ABS=0, frame {-5, -2, -9(last)} -> out_value=-2, out_index=1, out_count=3; single-sample frame {-4(last)} -> value=-4, index=0, count=1.
3. USE_ABS=1, frame {32'h80000000, 100(last)} -> out_value=32'h7FFFFFFF, out_index=0.
4. Backpressure: hold out_ready=0 for 5 cycles after frame 1 -> out_* stable and in_ready=0 throughout; a source holding in_valid=1 loses no data, and frame 2 results arrive correctly after release.
5. MAX_LEN=4, feed 6 beats {1,9,2,3,8,4(last)} -> result 1: value=9, index=1, count=4, overflow=1; result 2: value=8, index=0, count=2, overflow=0.
6. Assert resetN=0 after 2 beats of a frame, then send frame {6, 2(last)} -> all outputs 0 during reset; result value=6, index=0, count=2 with no contamination from the aborted frame.
